// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Holds the request record, arbitration policy codes and the one-hot decode helper.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_P1   = 2'd2
    } gnt_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wr_req_t;

    // Hazard logic wants one bit per architectural register.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        rd_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << rd;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_rr_arbiter.sv
// Two-way writeback grant logic: round-robin, or fixed priority to port 0
// with a wait counter that lets port 1 through after WAIT_MAX denied cycles.
module wb_rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR,
    parameter int WAIT_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic hold,
    output logic grant0,
    output logic grant1
);

    localparam logic [3:0] WAIT_MAX_C = 4'(WAIT_MAX);

    logic       last1_r;
    logic [3:0] wait_cnt_r;
    logic [3:0] wait_cnt_nxt_s;
    gnt_t       gnt_s;

    // Grant decision from valids, hold and arbiter history.
    always_comb begin
        gnt_s = GNT_NONE;
        if (hold) begin
            gnt_s = GNT_NONE;
        end else if (valid0 && valid1) begin
            if (ARB_MODE == ARB_FIXED) begin
                gnt_s = (wait_cnt_r == WAIT_MAX_C) ? GNT_P1 : GNT_P0;
            end else begin
                gnt_s = last1_r ? GNT_P0 : GNT_P1;
            end
        end else if (valid0) begin
            gnt_s = GNT_P0;
        end else if (valid1) begin
            gnt_s = GNT_P1;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Grants are suppressed while reset is held so no handshake completes then.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (gnt_s)
            GNT_P0:  grant0 = rst_n;
            GNT_P1:  grant1 = rst_n;
            default: begin
                grant0 = 1'b0;
                grant1 = 1'b0;
            end
        endcase
    end

    // Starvation counter: counts denied port-1 cycles, hold cycles included.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        if (ARB_MODE != ARB_FIXED) begin
            wait_cnt_nxt_s = 4'd0;
        end else if (!valid1 || (gnt_s == GNT_P1)) begin
            wait_cnt_nxt_s = 4'd0;
        end else if (wait_cnt_r < WAIT_MAX_C) begin
            wait_cnt_nxt_s = wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // Arbiter history registers; last-grant pointer resets to port 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last1_r    <= 1'b1;
            wait_cnt_r <= 4'd0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
            case (gnt_s)
                GNT_P0:  last1_r <= 1'b0;
                GNT_P1:  last1_r <= 1'b1;
                default: last1_r <= last1_r;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU (port 0) and LSU (port 1).
// One grant per cycle; the winning write is registered and issued one cycle later.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR,
    parameter int WAIT_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [REG_ADDR_W-1:0] req0_rd_i,
    input  logic [XLEN-1:0]       req0_data_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [REG_ADDR_W-1:0] req1_rd_i,
    input  logic [XLEN-1:0]       req1_data_i,
    input  logic                  hold_i,
    output logic [XLEN-1:0]       reg_wr_data_o,
    output logic [REG_ADDR_W-1:0] reg_wr_reg_o,
    output logic                  ctrl_reg_we_o,
    output logic [NUM_REGS-1:0]   wb_pend_o
);

    logic                  grant0_s;
    logic                  grant1_s;
    logic                  xfer_s;
    wr_req_t               req_s;
    logic                  we_r;
    logic [REG_ADDR_W-1:0] reg_r;
    logic [XLEN-1:0]       data_r;
    logic [NUM_REGS-1:0]   pend_r;

    wb_rr_arbiter #(
        .ARB_MODE (ARB_MODE),
        .WAIT_MAX (WAIT_MAX)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid_i),
        .valid1 (req1_valid_i),
        .hold   (hold_i),
        .grant0 (grant0_s),
        .grant1 (grant1_s)
    );

    assign req0_ready_o = grant0_s;
    assign req1_ready_o = grant1_s;
    assign xfer_s       = grant0_s | grant1_s;

    // Select the winning request record.
    always_comb begin
        req_s = '0;
        if (grant1_s) begin
            req_s.rd   = req1_rd_i;
            req_s.data = req1_data_i;
        end else begin
            req_s.rd   = req0_rd_i;
            req_s.data = req0_data_i;
        end
    end

    // Output stage: x0 transfers are consumed without touching the write port,
    // and address/data are left untouched when nothing is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r   <= 1'b0;
            reg_r  <= '0;
            data_r <= '0;
            pend_r <= '0;
        end else if (xfer_s && (req_s.rd != 5'd0)) begin
            we_r   <= 1'b1;
            reg_r  <= req_s.rd;
            data_r <= req_s.data;
            pend_r <= rd_onehot(req_s.rd);
        end else begin
            we_r   <= 1'b0;
            pend_r <= '0;
        end
    end

    assign ctrl_reg_we_o = we_r;
    assign reg_wr_reg_o  = reg_r;
    assign reg_wr_data_o = data_r;
    assign wb_pend_o     = pend_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: one round-robin and one fixed-priority instance,
// directed scenarios with literal expectations, then random traffic against a model.
module tb_regfile_wb_arbiter;

    localparam int WAIT_MAX = 4;

    logic        clk;
    logic        rst_n;
    logic        v0 [2];
    logic        v1 [2];
    logic        hold [2];
    logic [4:0]  rd0 [2];
    logic [4:0]  rd1 [2];
    logic [31:0] d0 [2];
    logic [31:0] d1 [2];
    logic        r0 [2];
    logic        r1 [2];
    logic        we [2];
    logic [4:0]  wreg [2];
    logic [31:0] wdata [2];
    logic [31:0] pend [2];

    // model state per instance (index 0 = round-robin, 1 = fixed priority)
    bit          last1_m [2];
    int          wait_m [2];
    bit          exp_we [2];
    logic [4:0]  exp_reg [2];
    logic [31:0] exp_data [2];
    bit          known [2];
    int          g_last [2];
    bit          rdy0_seen [2];
    bit          rdy1_seen [2];

    int pass_cnt  = 0;
    int total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter #(.ARB_MODE(0), .WAIT_MAX(WAIT_MAX)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(v0[0]), .req0_ready_o(r0[0]), .req0_rd_i(rd0[0]), .req0_data_i(d0[0]),
        .req1_valid_i(v1[0]), .req1_ready_o(r1[0]), .req1_rd_i(rd1[0]), .req1_data_i(d1[0]),
        .hold_i(hold[0]), .reg_wr_data_o(wdata[0]), .reg_wr_reg_o(wreg[0]),
        .ctrl_reg_we_o(we[0]), .wb_pend_o(pend[0])
    );

    regfile_wb_arbiter #(.ARB_MODE(1), .WAIT_MAX(WAIT_MAX)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(v0[1]), .req0_ready_o(r0[1]), .req0_rd_i(rd0[1]), .req0_data_i(d0[1]),
        .req1_valid_i(v1[1]), .req1_ready_o(r1[1]), .req1_rd_i(rd1[1]), .req1_data_i(d1[1]),
        .hold_i(hold[1]), .reg_wr_data_o(wdata[1]), .reg_wr_reg_o(wreg[1]),
        .ctrl_reg_we_o(we[1]), .wb_pend_o(pend[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s[inst%0d] @%0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    endtask

    // 0 = no grant, 1 = port 0, 2 = port 1
    function automatic int model_grant(input int k);
        if (hold[k]) return 0;
        if (v0[k] && v1[k]) begin
            if (k == 0) return last1_m[k] ? 1 : 2;
            return (wait_m[k] >= WAIT_MAX) ? 2 : 1;
        end
        if (v0[k]) return 1;
        if (v1[k]) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last1_m[k]  = 1'b1;
            wait_m[k]   = 0;
            exp_we[k]   = 1'b0;
            exp_reg[k]  = 5'd0;
            exp_data[k] = 32'd0;
            known[k]    = 1'b1;
            g_last[k]   = 0;
        end
    endtask

    task automatic model_update(input int k, input int g);
        logic [4:0]  rd;
        logic [31:0] dt;
        rd = (g == 2) ? rd1[k] : rd0[k];
        dt = (g == 2) ? d1[k] : d0[k];
        if (g != 0) begin
            last1_m[k] = (g == 2);
            if (rd != 5'd0) begin
                exp_we[k] = 1'b1; exp_reg[k] = rd; exp_data[k] = dt; known[k] = 1'b1;
            end else begin
                exp_we[k] = 1'b0; known[k] = 1'b0;
            end
        end else begin
            exp_we[k] = 1'b0;
        end
        if (k == 1) begin
            if (!v1[k] || g == 2) wait_m[k] = 0;
            else if (wait_m[k] < WAIT_MAX) wait_m[k] = wait_m[k] + 1;
        end
    endtask

    task automatic check_outputs(input int k);
        chk("we", k, we[k], exp_we[k]);
        chk("wb_pend", k, pend[k], exp_we[k] ? (32'd1 << exp_reg[k]) : 32'd0);
        if (known[k]) begin
            chk("wr_reg", k, wreg[k], exp_reg[k]);
            chk("wr_data", k, wdata[k], exp_data[k]);
        end
    endtask

    // One clock: check readies, advance model, then check registered outputs.
    task automatic step();
        int g;
        #1;
        for (int k = 0; k < 2; k++) begin
            g = model_grant(k);
            rdy0_seen[k] = r0[k];
            rdy1_seen[k] = r1[k];
            chk("ready0", k, r0[k], (g == 1));
            chk("ready1", k, r1[k], (g == 2));
            model_update(k, g);
            g_last[k] = g;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_outputs(k);
    endtask

    task automatic set_in(input int k, input bit a0, input logic [4:0] ra0, input logic [31:0] da0,
                          input bit a1, input logic [4:0] ra1, input logic [31:0] da1, input bit h);
        v0[k] = a0; rd0[k] = ra0; d0[k] = da0;
        v1[k] = a1; rd1[k] = ra1; d1[k] = da1;
        hold[k] = h;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) set_in(k, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd4, 32'h5A5A5A5A, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready0", k, r0[k], 1'b0);
            chk("rst_ready1", k, r1[k], 1'b0);
            chk("rst_we", k, we[k], 1'b0);
            chk("rst_reg", k, wreg[k], 5'd0);
            chk("rst_data", k, wdata[k], 32'd0);
            chk("rst_pend", k, pend[k], 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) set_in(k, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        model_reset();
    endtask

    logic [4:0] rr_seq [12] = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14, 5'd5, 5'd15, 5'd6, 5'd16};
    logic [4:0] fx_seq [12] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd11, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};

    initial begin
        int         i0 [2];
        int         i1 [2];
        int         nobs [2];
        logic [4:0] obs [2][12];

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) set_in(k, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        do_reset();

        // single request on port 0
        for (int k = 0; k < 2; k++) set_in(k, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
        step();
        for (int k = 0; k < 2; k++) begin
            chk("lit_single_ready", k, rdy0_seen[k], 1'b1);
            chk("lit_single_we", k, we[k], 1'b1);
            chk("lit_single_reg", k, wreg[k], 5'd5);
            chk("lit_single_data", k, wdata[k], 32'hDEADBEEF);
            chk("lit_single_pend", k, pend[k], 32'h00000020);
            set_in(k, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        end
        step();
        for (int k = 0; k < 2; k++) chk("lit_single_we_drop", k, we[k], 1'b0);

        // continuous contention: 6 requests per port
        do_reset();
        for (int k = 0; k < 2; k++) begin
            i0[k] = 0; i1[k] = 0; nobs[k] = 0;
            for (int j = 0; j < 12; j++) obs[k][j] = 5'd0;
        end
        for (int cyc = 0; cyc < 16; cyc++) begin
            for (int k = 0; k < 2; k++)
                set_in(k, (i0[k] < 6), 5'(i0[k] + 1), 32'h100 + 32'(i0[k]),
                          (i1[k] < 6), 5'(i1[k] + 11), 32'h200 + 32'(i1[k]), 1'b0);
            step();
            for (int k = 0; k < 2; k++) begin
                if (g_last[k] == 1) i0[k]++;
                if (g_last[k] == 2) i1[k]++;
                if (we[k] && nobs[k] < 12) begin
                    obs[k][nobs[k]] = wreg[k];
                    nobs[k]++;
                end
            end
        end
        for (int k = 0; k < 2; k++) chk("lit_burst_count", k, nobs[k], 12);
        for (int j = 0; j < 12; j++) begin
            chk($sformatf("lit_rr_order%0d", j), 0, obs[0][j], rr_seq[j]);
            chk($sformatf("lit_fx_order%0d", j), 1, obs[1][j], fx_seq[j]);
        end

        // x0 write on port 1, then contention
        do_reset();
        for (int k = 0; k < 2; k++) set_in(k, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678, 1'b0);
        step();
        for (int k = 0; k < 2; k++) begin
            chk("lit_x0_ready", k, rdy1_seen[k], 1'b1);
            chk("lit_x0_we", k, we[k], 1'b0);
            chk("lit_x0_pend", k, pend[k], 32'd0);
            set_in(k, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b0);
        end
        step();
        chk("lit_x0_rr_next", 0, rdy0_seen[0], 1'b1);

        // hold with both valid, then release
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 2; k++) set_in(k, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b1);
            step();
            for (int k = 0; k < 2; k++) begin
                chk("lit_hold_r0", k, rdy0_seen[k], 1'b0);
                chk("lit_hold_r1", k, rdy1_seen[k], 1'b0);
                chk("lit_hold_we", k, we[k], 1'b0);
            end
        end
        for (int k = 0; k < 2; k++) set_in(k, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b0);
        step();
        for (int k = 0; k < 2; k++) begin
            chk("lit_release_p0", k, rdy0_seen[k], 1'b1);
            set_in(k, 1'b1, 5'd9, 32'h99, 1'b1, 5'd8, 32'h88, 1'b0);
        end
        step();
        for (int k = 0; k < 2; k++) chk("lit_release_then_p1", k, rdy1_seen[k], 1'b1);

        // async reset in the middle of a burst
        do_reset();
        for (int k = 0; k < 2; k++) set_in(k, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("lit_async_we", k, we[k], 1'b0);
            chk("lit_async_reg", k, wreg[k], 5'd0);
            chk("lit_async_data", k, wdata[k], 32'd0);
            chk("lit_async_pend", k, pend[k], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 2; k++) set_in(k, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0);
        step();
        for (int k = 0; k < 2; k++) chk("lit_after_rst_p0", k, rdy0_seen[k], 1'b1);

        // random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            for (int k = 0; k < 2; k++) begin
                if (!v0[k] || g_last[k] == 1) begin
                    v0[k]  = ($urandom_range(0, 3) != 0);
                    rd0[k] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    d0[k]  = $urandom;
                end
                if (!v1[k] || g_last[k] == 2) begin
                    v1[k]  = ($urandom_range(0, 3) != 0);
                    rd1[k] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    d1[k]  = $urandom;
                end
                hold[k] = ($urandom_range(0, 7) == 0);
            end
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: port 0 (ALU result) and port 1 (load data from the LSU).
- Each port uses a valid/ready handshake. One request is granted per cycle. The granted write is registered and presented to the register file write port one cycle later.
- Writes to x0 are consumed but never reach the write port.
- Sits between the execute/memory stages and the register file write interface.

Parameters:
- ARB_MODE, 0, arbitration policy: 0 = round-robin; 1 = fixed priority to port 0 with a starvation guard for port 1.
- WAIT_MAX, 4, mode 1 only: once port 1 has been denied this many consecutive cycles, it gets priority on the next cycle. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- req0_valid_i  in  1  port 0 write request
- req0_ready_o  out  1  port 0 request accepted this cycle
- req0_rd_i  in  5  port 0 destination register
- req0_data_i  in  32  port 0 write data
- req1_valid_i  in  1  port 1 write request
- req1_ready_o  out  1  port 1 request accepted this cycle
- req1_rd_i  in  5  port 1 destination register
- req1_data_i  in  32  port 1 write data
- hold_i  in  1  freeze: no grants while high
- reg_wr_data_o  out  32  to register file write data
- reg_wr_reg_o  out  5  to register file write register
- ctrl_reg_we_o  out  1  to register file write enable
- wb_pend_o  out  32  one-hot of the register being written this cycle; all zero when ctrl_reg_we_o = 0

Behaviour:
- Reset (async, rst_n low): every output and internal register is forced to reset value.
  - ctrl_reg_we_o = 0, reg_wr_reg_o = 0, reg_wr_data_o = 0, wb_pend_o = 0.
  - Last-grant pointer = 1, so port 0 wins the first contention.
  - Wait counter = 0.
  - reqN_ready_o = 0 while rst_n is low.
- Handshake:
  - reqN_ready_o is combinational from the valids, hold_i and arbiter state.
  - At most one of req0_ready_o / req1_ready_o is high in any cycle.
  - A transfer occurs when valid and ready are both high. Requesters hold valid, rd and data stable until accepted.
  - ready is never high when the matching valid is low.
- Grant rules:
  - hold_i = 1: no grant.
  - Only one port valid: that port is granted.
  - Both valid, ARB_MODE 0: grant the port not granted last. Round-robin on actual transfers only.
  - Both valid, ARB_MODE 1: grant port 0, unless the wait counter equals WAIT_MAX; then grant port 1.
- Wait counter (mode 1 only):
  - Increments when req1_valid_i = 1 and port 1 is not granted, saturating at WAIT_MAX.
  - Clears on a port 1 grant, or when req1_valid_i = 0.
  - Cycles under hold_i increment it too.
- Output stage, 1-cycle latency:
  - A transfer in cycle N drives ctrl_reg_we_o = 1 with the granted rd/data in cycle N+1, for exactly one cycle.
  - No transfer in cycle N: ctrl_reg_we_o = 0 in N+1. reg_wr_reg_o / reg_wr_data_o keep their previous values.
  - The register file always accepts a write, so there is no backpressure. Throughput is one write per cycle, sustained back-to-back.
- x0 writes:
  - A transfer with rd = 0 completes the handshake and counts as a grant for round-robin and the wait counter.
  - It produces ctrl_reg_we_o = 0 and wb_pend_o = 0 in N+1.
- wb_pend_o = ctrl_reg_we_o ? (1 << reg_wr_reg_o) : 0. Hazard logic uses it to stall reads of that register.
- Same rd on both ports in the same cycle: arbitrate normally; the loser is written later. Program order is the requesters' responsibility.
- Reset mid-operation: an in-flight output-stage write is dropped (we forced low). Requests not yet accepted must be re-presented after reset.

Decomposition:
- Shared package holds:
  - REG_ADDR_W = 5, XLEN = 32, NUM_REGS = 32.
  - ARB_RR = 0, ARB_FIXED = 1.
  - A write-request struct: rd, data.
- One sub-module is natural: wb_rr_arbiter, a 2-way grant logic with last-grant pointer and wait counter, parameterised by ARB_MODE/WAIT_MAX. The top level adds the output register stage, x0 squash and wb_pend_o decode.

Test Plan:
- Reset, then a single request: req0 rd=5 data=0xDEADBEEF valid one cycle -> req0_ready_o=1 same cycle; next cycle ctrl_reg_we_o=1, reg_wr_reg_o=5, reg_wr_data_o=0xDEADBEEF, wb_pend_o=0x00000020; following cycle we=0.
- ARB_MODE 0 contention: both ports valid continuously for 4 transfers (rd 1..4 on port 0, rd 11..14 on port 1) -> grants 0,1,0,1; outputs 1,11,2,12 on consecutive cycles with we held high.
- ARB_MODE 1, WAIT_MAX=4, both ports valid continuously -> port 0 granted cycles 0-3, port 1 granted cycle 4, counter back to 0, then port 0 again.
- x0 squash: req1 rd=0 data=0x12345678 -> ready=1; next cycle we=0, wb_pend_o=0; round-robin pointer advances (next contention favours port 0).
- hold_i=1 for 3 cycles with both ports valid -> both ready=0 and we=0 throughout; hold_i release -> grant resumes per policy.
- Async reset asserted mid-burst while we=1 -> outputs go to 0 immediately (no clock edge); after release, first contention grants port 0.
